// File: rtl/debounce_pulse_pkg.sv
// Shared types and sizing helpers for the button debouncer / pulse generator.
// The package name is what the other files import, independent of this file's name.
package debounce_pkg;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      PRESS_DB    = 3'd1,
      HELD_DELAY  = 3'd2,
      HELD_REPEAT = 3'd3,
      RELEASE_DB  = 3'd4
   } debounce_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   // Wide enough to hold the largest terminal count plus one; never below 1 bit.
   function automatic int timer_width(input int stable_cycles, input int repeat_delay,
                                      input int repeat_period);
      int w;
      w = $clog2(max3(stable_cycles, repeat_delay, repeat_period) + 1);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/debounce_pulse_sync_2ff.sv
// Two-flop synchronizer bringing the raw button into the clk domain.
// Both stages clear on reset so a held button is seen as a fresh press afterwards.
module sync_2ff (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/debounce_pulse.sv
// Button debouncer: registered press strobe with optional auto-repeat, plus debounced level.
//
//   state       | meaning
//   ------------+-------------------------------------------------------------
//   IDLE        | button released and stable, level=0
//   PRESS_DB    | counting consecutive high samples before accepting a press
//   HELD_DELAY  | press accepted; waiting REPEAT_DELAY before auto-repeat
//   HELD_REPEAT | auto-repeat active, one strobe every REPEAT_PERIOD cycles
//   RELEASE_DB  | counting consecutive low samples before accepting release
module debounce_pulse
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = 16,
   parameter int REPEAT_DELAY  = 0,
   parameter int REPEAT_PERIOD = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_in,
   output logic pulse,
   output logic level
);

   localparam int TW = timer_width(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

   localparam logic [TW-1:0] STABLE_TC = TW'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0] DELAY_TC  = TW'((REPEAT_DELAY > 0) ? (REPEAT_DELAY - 1) : 0);
   localparam logic [TW-1:0] PERIOD_TC = TW'(REPEAT_PERIOD - 1);
   localparam logic [TW-1:0] TIMER_ONE = TW'(1);
   localparam bit            REPEAT_EN = (REPEAT_DELAY > 0);
   localparam bit            SINGLE_DB = (STABLE_CYCLES == 1);

   initial begin
      if (STABLE_CYCLES < 1)
         $error("debounce_pulse: STABLE_CYCLES (%0d) must be >= 1", STABLE_CYCLES);
      if (REPEAT_DELAY < 0)
         $error("debounce_pulse: REPEAT_DELAY (%0d) must be >= 0", REPEAT_DELAY);
      if (REPEAT_PERIOD < 1)
         $error("debounce_pulse: REPEAT_PERIOD (%0d) must be >= 1", REPEAT_PERIOD);
   end

   logic            sync;
   debounce_state_t state;
   debounce_state_t state_next;
   logic [TW-1:0]   timer;
   logic [TW-1:0]   timer_next;
   logic            pulse_next;
   logic            level_next;

   sync_2ff u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (btn_in),
      .q       (sync)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         timer <= '0;
         pulse <= 1'b0;
         level <= 1'b0;
      end else begin
         state <= state_next;
         timer <= timer_next;
         pulse <= pulse_next;
         level <= level_next;
      end
   end

   // Every terminal-count compare either changes state or reloads the timer, so it never wraps.
   always_comb begin
      state_next = state;
      timer_next = timer;
      case (state)
         IDLE: begin
            if (sync) begin
               if (SINGLE_DB) begin
                  state_next = HELD_DELAY;
                  timer_next = '0;
               end else begin
                  state_next = PRESS_DB;
                  timer_next = TIMER_ONE;
               end
            end
         end
         PRESS_DB: begin
            if (!sync) begin
               state_next = IDLE;
               timer_next = '0;
            end else if (timer == STABLE_TC) begin
               state_next = HELD_DELAY;
               timer_next = '0;
            end else begin
               timer_next = timer + TIMER_ONE;
            end
         end
         HELD_DELAY, HELD_REPEAT: begin
            if (!sync) begin
               if (SINGLE_DB) begin
                  state_next = IDLE;
                  timer_next = '0;
               end else begin
                  state_next = RELEASE_DB;
                  timer_next = TIMER_ONE;
               end
            end else if (state == HELD_REPEAT) begin
               if (timer == PERIOD_TC) timer_next = '0;
               else                    timer_next = timer + TIMER_ONE;
            end else if (REPEAT_EN) begin
               if (timer == DELAY_TC) begin
                  state_next = HELD_REPEAT;
                  timer_next = '0;
               end else begin
                  timer_next = timer + TIMER_ONE;
               end
            end
         end
         RELEASE_DB: begin
            if (sync) begin
               state_next = HELD_DELAY;
               timer_next = '0;
            end else if (timer == STABLE_TC) begin
               state_next = IDLE;
               timer_next = '0;
            end else begin
               timer_next = timer + TIMER_ONE;
            end
         end
         default: begin
            state_next = IDLE;
            timer_next = '0;
         end
      endcase
   end

   // Strobes only on press acceptance and repeat ticks; bouncing back from RELEASE_DB is silent.
   always_comb begin
      pulse_next = 1'b0;
      case (state)
         IDLE, PRESS_DB: pulse_next = (state_next == HELD_DELAY);
         HELD_DELAY:     pulse_next = (state_next == HELD_REPEAT);
         HELD_REPEAT:    pulse_next = sync && (timer == PERIOD_TC);
         default:        pulse_next = 1'b0;
      endcase
      level_next = (state_next == HELD_DELAY) || (state_next == HELD_REPEAT) ||
                   (state_next == RELEASE_DB);
   end

endmodule
